// File: rtl/axi_default_slave_pkg.sv
// Shared encodings for the AXI default slave: response codes, FSM states and
// the AXI3/AXI4-dependent length and lock widths.
package axi_default_slave_pkg;

`ifdef AMBA_AXI4
   localparam int unsigned AxiWidthLen  = 8;
   localparam int unsigned AxiWidthLock = 1;
`else
   localparam int unsigned AxiWidthLen  = 4;
   localparam int unsigned AxiWidthLock = 2;
`endif

   typedef enum logic [1:0] {
      RespOkay   = 2'b00,
      RespExokay = 2'b01,
      RespSlverr = 2'b10,
      RespDecerr = 2'b11
   } axi_resp_e;

   typedef enum logic [1:0] {
      WIdle = 2'b00,
      WData = 2'b01,
      WResp = 2'b10
   } w_state_e;

   typedef enum logic {
      RIdle = 1'b0,
      RData = 1'b1
   } r_state_e;

endpackage

// File: rtl/axi_default_slave_if.sv
// AXI bus bundle between an interconnect master port and the default slave.
interface axi_default_slave_if #(
   parameter int unsigned AXI_WIDTH_CID = 4,
   parameter int unsigned AXI_WIDTH_ID  = 4,
   parameter int unsigned AXI_WIDTH_AD  = 32,
   parameter int unsigned AXI_WIDTH_DA  = 32,
   parameter int unsigned AXI_WIDTH_DS  = AXI_WIDTH_DA / 8,
   parameter int unsigned AXI_WIDTH_SID = AXI_WIDTH_CID + AXI_WIDTH_ID
);

   localparam int unsigned LenW  = axi_default_slave_pkg::AxiWidthLen;
   localparam int unsigned LockW = axi_default_slave_pkg::AxiWidthLock;

   logic [AXI_WIDTH_SID-1:0] AWID;
   logic [AXI_WIDTH_AD-1:0]  AWADDR;
   logic [LenW-1:0]          AWLEN;
   logic [2:0]               AWSIZE;
   logic [1:0]               AWBURST;
   logic [LockW-1:0]         AWLOCK;
   logic                     AWVALID;
   logic                     AWREADY;

   logic [AXI_WIDTH_SID-1:0] WID;
   logic [AXI_WIDTH_DA-1:0]  WDATA;
   logic [AXI_WIDTH_DS-1:0]  WSTRB;
   logic                     WLAST;
   logic                     WVALID;
   logic                     WREADY;

   logic [AXI_WIDTH_SID-1:0] BID;
   logic [1:0]               BRESP;
   logic                     BVALID;
   logic                     BREADY;

   logic [AXI_WIDTH_SID-1:0] ARID;
   logic [AXI_WIDTH_AD-1:0]  ARADDR;
   logic [LenW-1:0]          ARLEN;
   logic [2:0]               ARSIZE;
   logic [1:0]               ARBURST;
   logic [LockW-1:0]         ARLOCK;
   logic                     ARVALID;
   logic                     ARREADY;

   logic [AXI_WIDTH_SID-1:0] RID;
   logic [AXI_WIDTH_DA-1:0]  RDATA;
   logic [1:0]               RRESP;
   logic                     RLAST;
   logic                     RVALID;
   logic                     RREADY;

   modport slave (
      input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWVALID,
      output AWREADY,
      input  WID, WDATA, WSTRB, WLAST, WVALID,
      output WREADY,
      output BID, BRESP, BVALID,
      input  BREADY,
      input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARVALID,
      output ARREADY,
      output RID, RDATA, RRESP, RLAST, RVALID,
      input  RREADY
   );

   modport master (
      output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWVALID,
      input  AWREADY,
      output WID, WDATA, WSTRB, WLAST, WVALID,
      input  WREADY,
      input  BID, BRESP, BVALID,
      output BREADY,
      output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARVALID,
      input  ARREADY,
      input  RID, RDATA, RRESP, RLAST, RVALID,
      output RREADY
   );

endinterface

// File: rtl/axi_default_slave.sv
// AXI slave that completes every access with DECERR so unmapped regions never hang
// the bus. Independent write and read FSMs, one outstanding transaction each.
module axi_default_slave
   import axi_default_slave_pkg::*;
#(
   parameter int unsigned AXI_WIDTH_CID = 4,
   parameter int unsigned AXI_WIDTH_ID  = 4,
   parameter int unsigned AXI_WIDTH_AD  = 32,
   parameter int unsigned AXI_WIDTH_DA  = 32,
   parameter int unsigned AXI_WIDTH_DS  = AXI_WIDTH_DA / 8,
   parameter int unsigned AXI_WIDTH_SID = AXI_WIDTH_CID + AXI_WIDTH_ID
) (
   input logic                 ACLK,
   input logic                 ARESETn,
   axi_default_slave_if.slave  s
);

   // ---------------- write path ----------------
   w_state_e                 w_state_q, w_state_d;
   logic [AXI_WIDTH_SID-1:0] bid_q, bid_d;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         w_state_q <= WIdle;
         bid_q     <= '0;
      end else begin
         w_state_q <= w_state_d;
         bid_q     <= bid_d;
      end
   end

   // WLAST alone closes the burst; beat count and WID are deliberately not checked.
   always_comb begin
      w_state_d = w_state_q;
      bid_d     = bid_q;
      unique case (w_state_q)
         WIdle: begin
            if (s.AWVALID) begin
               bid_d     = s.AWID;
               w_state_d = WData;
            end
         end
         WData: begin
            if (s.WVALID && s.WLAST) w_state_d = WResp;
         end
         WResp: begin
            if (s.BREADY) w_state_d = WIdle;
         end
         default: w_state_d = WIdle;
      endcase
   end

   assign s.AWREADY = (w_state_q == WIdle);
   assign s.WREADY  = (w_state_q == WData);
   assign s.BVALID  = (w_state_q == WResp);
   assign s.BID     = bid_q;
   assign s.BRESP   = RespDecerr;

   // ---------------- read path ----------------
   r_state_e                 r_state_q, r_state_d;
   logic [AXI_WIDTH_SID-1:0] rid_q, rid_d;
   logic [AxiWidthLen-1:0]   rlen_q, rlen_d;
   logic [AxiWidthLen-1:0]   rcnt_q, rcnt_d;
   logic                     rlast;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_state_q <= RIdle;
         rid_q     <= '0;
         rlen_q    <= '0;
         rcnt_q    <= '0;
      end else begin
         r_state_q <= r_state_d;
         rid_q     <= rid_d;
         rlen_q    <= rlen_d;
         rcnt_q    <= rcnt_d;
      end
   end

   // Gate with state so RLAST stays low in idle even though cnt == len there.
   assign rlast = (r_state_q == RData) && (rcnt_q == rlen_q);

   // Counter only moves on a non-final handshake, so it never wraps past ARLEN.
   always_comb begin
      r_state_d = r_state_q;
      rid_d     = rid_q;
      rlen_d    = rlen_q;
      rcnt_d    = rcnt_q;
      unique case (r_state_q)
         RIdle: begin
            if (s.ARVALID) begin
               rid_d     = s.ARID;
               rlen_d    = s.ARLEN;
               rcnt_d    = '0;
               r_state_d = RData;
            end
         end
         RData: begin
            if (s.RREADY) begin
               if (rlast) r_state_d = RIdle;
               else       rcnt_d    = rcnt_q + 1'b1;
            end
         end
      endcase
   end

   assign s.ARREADY = (r_state_q == RIdle);
   assign s.RVALID  = (r_state_q == RData);
   assign s.RLAST   = rlast;
   assign s.RID     = rid_q;
   assign s.RRESP   = RespDecerr;
   assign s.RDATA   = '0;

   // Address, data and burst attributes are accepted but irrelevant to a DECERR target.
   logic [AXI_WIDTH_AD-1:0] unused_awaddr;
   logic [AXI_WIDTH_AD-1:0] unused_araddr;
   logic [AXI_WIDTH_DS-1:0] unused_wstrb;
   logic                    unused_misc;

   assign unused_awaddr = s.AWADDR;
   assign unused_araddr = s.ARADDR;
   assign unused_wstrb  = s.WSTRB;
   assign unused_misc   = ^{s.AWLEN, s.AWSIZE, s.AWBURST, s.AWLOCK, s.WID, s.WDATA,
                            s.ARSIZE, s.ARBURST, s.ARLOCK};

endmodule

// File: doc/axi_default_slave.md
Name: axi_default_slave

Overview:
- AXI slave that terminates every transaction it receives with DECERR.
- Sits on the M_* side of the sync AXI bridge and serves unmapped address regions behind the interconnect, so a stray access completes instead of hanging the bus.
- Write and read paths are independent state machines. Each path has one transaction outstanding at a time.
- Full AXI ID is echoed on responses, so the channel-ID prefix routes responses back correctly.

Parameters:
AXI_WIDTH_CID, 4, channel-ID width
AXI_WIDTH_ID, 4, transaction ID width
AXI_WIDTH_AD, 32, address width
AXI_WIDTH_DA, 32, data width
AXI_WIDTH_DS, AXI_WIDTH_DA/8, strobe width
AXI_WIDTH_SID, AXI_WIDTH_CID+AXI_WIDTH_ID, full ID width

Ports:
ACLK  in  1  single clock; all logic on rising edge
ARESETn  in  1  asynchronous active-low reset
AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWLOCK  in  SID/AD/4/3/2/2  write address (AWLEN 8 bits, AWLOCK 1 bit under AMBA_AXI4); only AWID stored
AWVALID in 1; AWREADY out 1  write address handshake
WID/WDATA/WSTRB  in  SID/DA/DS  write data, discarded
WLAST in 1; WVALID in 1; WREADY out 1  write data handshake
BID out SID; BRESP out 2; BVALID out 1; BREADY in 1  write response
ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARLOCK  in  SID/AD/4/3/2/2  read address (AXI4 widths as for AW); ARID and ARLEN stored
ARVALID in 1; ARREADY out 1  read address handshake
RID out SID; RDATA out DA; RRESP out 2; RLAST out 1; RVALID out 1; RREADY in 1  read data

Behaviour:

Reset:
- Both FSMs go to IDLE.
- AWREADY=1, ARREADY=1. WREADY, BVALID, RVALID, RLAST = 0.
- BID, RID = 0. BRESP, RRESP = 2'b11. RDATA = 0 always.
- Reset asserted mid-transaction aborts it immediately, with no response issued.

Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE
- W_IDLE: AWREADY=1, WREADY=0. On AWVALID&AWREADY, latch AWID and go to W_DATA next cycle.
- W_DATA: AWREADY=0, WREADY=1. Each WVALID beat is consumed. WSTRB and WID are ignored; no WID/AWID check.
- W_DATA exit: a beat with WLAST=1 moves to W_RESP. Beat count is not checked; WLAST alone ends the burst.
- W_RESP: BVALID=1, BID=latched AWID, BRESP=DECERR. BVALID holds until BREADY, then go to W_IDLE.
- Minimum write cycle for a single-beat burst: AW, W, B on three consecutive cycles. AWREADY reasserts the cycle after the B handshake.
- W data arriving before AW is held off (WREADY=0) until AW is accepted.

Read FSM: R_IDLE -> R_DATA -> R_IDLE
- R_IDLE: ARREADY=1. On ARVALID&ARREADY, latch ARID and ARLEN, clear the beat counter, and go to R_DATA next cycle.
- R_DATA: ARREADY=0, RVALID=1, RID=latched ARID, RRESP=DECERR, RDATA=0.
- RLAST=1 when counter==latched ARLEN. The counter is the same width as ARLEN and advances only on RVALID&RREADY.
- R_DATA exit: a handshake with RLAST=1 returns to R_IDLE, with RVALID=0 the next cycle.
- Burst length is ARLEN+1 beats. ARLEN=15 gives 16 beats (255 gives 256 under AXI4); the counter never wraps past ARLEN.
- RREADY low stalls the bus: RVALID, RID and RLAST are held stable (AXI rule). The counter must not advance.

Simultaneous events:
- AW and AR accepted in the same cycle are handled concurrently with no interaction.
- B and R handshakes can complete in the same cycle.

Decomposition:
- Shared package/include holds the response encodings (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11) and the FSM state encodings.
- The length width follows the AMBA_AXI4 define (4 or 8), consistent with the rest of the AXI blocks.
- No sub-module; the two FSMs live in one file as separate always blocks.

Test Plan:
- Reset then AW(AWID=8'h5A, AWLEN=0) + single W(WLAST=1), BREADY=1 -> BVALID on the third cycle, BID=8'h5A, BRESP=2'b11; AWREADY=1 the next cycle.
- AR(ARID=8'h13, ARLEN=3), RREADY=1 -> 4 consecutive beats with RID=8'h13, RRESP=2'b11, RDATA=0; RLAST only on beat 4; ARREADY back after beat 4.
- AR(ARLEN=15), RREADY toggled 1,0,0,1,... -> exactly 16 handshakes; RLAST, RID and RVALID held stable during stalls.
- W asserted 3 cycles before AW(AWLEN=2) -> WREADY=0 until AW is accepted, then 3 beats consumed; BREADY held low 5 cycles -> BVALID held high throughout.
- AW and AR (different IDs) in the same cycle -> both accepted; B and R complete independently with correct IDs.
- ARESETn asserted in the middle of an 8-beat read and a write burst -> RVALID, WREADY and BVALID drop asynchronously; after release both READY=1 and a fresh transaction completes normally.
